// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per clock on operand
// magnitudes, with sign fix-up on the final step and a valid/ready result port.
module ex_mdu #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  A,
    input  logic [XLEN-1:0]  B,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  Result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    logic              a_signed, b_signed, sa, sb, acc_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   spec_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi, mul_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_hi, div_lo, div_val, fix_res;

    // Operand decode at acceptance: signedness, magnitudes and the short-cut cases.
    always_comb begin
        a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
        sa       = a_signed & A[XLEN-1];
        sb       = b_signed & B[XLEN-1];
        a_mag    = sa ? (~A + 1'b1) : A;
        b_mag    = sb ? (~B + 1'b1) : B;
        // Remainder follows the dividend; everything else follows the operand signs.
        acc_neg  = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
        div_zero = funct3[2] & (B == '0);
        div_ovf  = funct3[2] & ~funct3[0] & (A == {1'b1, {(XLEN-1){1'b0}}}) & (B == '1);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            spec_res = funct3[1] ? A : '1;
        end else begin
            spec_res = funct3[1] ? '0 : A;
        end
    end

    // One datapath step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi    = mul_sum[XLEN:1];
        mul_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
        prod      = {mul_hi, mul_lo};
        prod_s    = neg_q ? (~prod + 1'b1) : prod;

        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_hi    = div_ge ? (div_shift[XLEN-1:0] - opb_q) : div_shift[XLEN-1:0];
        div_lo    = {lo_q[XLEN-2:0], div_ge};
        div_val   = f3_q[1] ? div_hi : div_lo;

        if (f3_q[2]) begin
            fix_res = neg_q ? (~div_val + 1'b1) : div_val;
        end else if (f3_q[1:0] == 2'b00) begin
            fix_res = prod_s[XLEN-1:0];
        end else begin
            fix_res = prod_s[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        res_d   = res_q;
        tag_d   = tag_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        f3_d  = funct3;
                        tag_d = tag_in;
                        neg_d = acc_neg;
                        if (special) begin
                            res_d   = spec_res;
                            state_d = DONE;
                        end else begin
                            state_d = CALC;
                            cnt_d   = '0;
                            hi_d    = '0;
                            lo_d    = funct3[2] ? a_mag : b_mag;
                            opb_d   = funct3[2] ? b_mag : a_mag;
                        end
                    end
                end
                CALC: begin
                    cnt_d = cnt_q + 1'b1;
                    hi_d  = f3_q[2] ? div_hi : mul_hi;
                    lo_d  = f3_q[2] ? div_lo : mul_lo;
                    if (cnt_q == LAST) begin
                        res_d   = fix_res;
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
        end
    end

    always_ff @(posedge clk) begin
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        opb_q <= opb_d;
        f3_q  <= f3_d;
        neg_q <= neg_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign Result    = res_q;
    assign tag_out   = tag_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: the driver queues expected results, the monitor
// checks result, tag and latency (edges after the accepting edge) on each handshake.
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [4:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Result;
    logic [4:0]  tag_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    bit   seen = 1'b0;

    ex_mdu #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .A(A), .B(B), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .tag_out(tag_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: latency on first valid, result/tag on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && !seen && sb.size() > 0) begin
                chk({sb[0].name, " latency"}, 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                seen = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%08h tag %0d, expected no result", Result, tag_out);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, " result"}, Result, e.res);
                    chk({e.name, " tag"}, 32'(tag_out), 32'(e.tag));
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input logic [31:0] r, input int lat,
                        input bit push, input string nm);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s accept_timeout: got in_ready=0, expected 1", nm);
            return;
        end
        funct3 = f; A = a; B = b; tag_in = t; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.res = r; e.tag = t; e.lat = lat; e.acc = cyc; e.name = nm;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL %s drain_timeout: got %0d pending, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s valid_timeout: got out_valid=0, expected 1", nm);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset Result", Result, 32'd0);
        chk("reset tag_out", 32'(tag_out), 32'd0);

        send(3'b000, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, 32, 1, "MUL");
        drain("MUL");
        send(3'b001, 32'h80000000, 32'h80000000, 5'd4, 32'h40000000, 32, 1, "MULH");
        drain("MULH");
        send(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFE, 32, 1, "MULHU");
        drain("MULHU");
        send(3'b010, 32'hFFFFFFFF, 32'd2, 5'd6, 32'hFFFFFFFF, 32, 1, "MULHSU");
        drain("MULHSU");
        send(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h00000000, 32, 1, "MULH_m1");
        drain("MULH_m1");
        send(3'b011, 32'h80000000, 32'd2, 5'd8, 32'h00000001, 32, 1, "MULHU_carry");
        drain("MULHU_carry");
        send(3'b000, 32'h12345678, 32'h10, 5'd9, 32'h23456780, 32, 1, "MUL_shift");
        drain("MUL_shift");
        // Short-cut cases complete on the accepting edge itself.
        send(3'b101, 32'h1234, 32'd0, 5'd10, 32'hFFFFFFFF, 0, 1, "DIVU_by0");
        drain("DIVU_by0");
        send(3'b110, 32'hFFFFFFF9, 32'd0, 5'd11, 32'hFFFFFFF9, 0, 1, "REM_by0");
        drain("REM_by0");
        send(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 0, 1, "DIV_ovf");
        drain("DIV_ovf");
        send(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 0, 1, "REM_ovf");
        drain("REM_ovf");
        send(3'b100, 32'hFFFFFFF9, 32'd2, 5'd14, 32'hFFFFFFFD, 32, 1, "DIV_neg");
        drain("DIV_neg");
        send(3'b110, 32'hFFFFFFF9, 32'd2, 5'd15, 32'hFFFFFFFF, 32, 1, "REM_neg");
        drain("REM_neg");
        send(3'b100, 32'd7, 32'hFFFFFFFE, 5'd16, 32'hFFFFFFFD, 32, 1, "DIV_negdiv");
        drain("DIV_negdiv");
        send(3'b110, 32'd7, 32'hFFFFFFFE, 5'd17, 32'h00000001, 32, 1, "REM_negdiv");
        drain("REM_negdiv");
        send(3'b111, 32'd100, 32'd7, 5'd18, 32'd2, 32, 1, "REMU");
        drain("REMU");

        // Back-pressure: result held for 10 cycles, a request during the stall is ignored.
        out_ready = 1'b0;
        send(3'b100, 32'hFFFFFFF9, 32'd2, 5'd19, 32'hFFFFFFFD, 32, 1, "DIV_stall");
        wait_valid("DIV_stall");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i == 3);
            funct3 = 3'b000; A = 32'd1; B = 32'd1; tag_in = 5'd20;
            #1;
            chk("stall Result", Result, 32'hFFFFFFFD);
            chk("stall tag_out", 32'(tag_out), 32'd19);
            chk("stall in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("DIV_stall");
        repeat (3) @(negedge clk);
        chk("stall no_second_op busy", 32'(busy), 32'd0);

        // Flush at CALC step 15, then a fresh divide.
        send(3'b000, 32'd5, 32'd6, 5'd21, 32'd30, 32, 0, "MUL_flushed");
        repeat (16) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        repeat (40) @(negedge clk);
        send(3'b101, 32'd100, 32'd7, 5'd22, 32'd14, 32, 1, "DIVU_after_flush");
        drain("DIVU_after_flush");

        // Reset while a result waits in DONE.
        out_ready = 1'b0;
        send(3'b000, 32'd2, 32'd3, 5'd23, 32'd6, 32, 0, "MUL_reset");
        wait_valid("MUL_reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_done out_valid", 32'(out_valid), 32'd0);
        chk("rst_done busy", 32'(busy), 32'd0);
        chk("rst_done in_ready", 32'(in_ready), 32'd1);
        chk("rst_done Result", Result, 32'd0);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
